// File: rtl/jtag_tap_ctrl_pkg.sv
// jtag_pkg: shared definitions for the JTAG TAP controller slice.
// Holds the IEEE 1149.1 TAP state encodings and helpers that derive the
// fixed opcodes from the instruction register width.
// Optional feature macro used by this slice: JTAG_IDCODE_EN.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [31:0] DEFAULT_IDCODE = 32'h0000_0765;

  // BYPASS is always the all-ones opcode.
  function automatic int unsigned bypass_opcode(input int unsigned irW);
    return (32'd1 << irW) - 32'd1;
  endfunction

  // IDCODE sits just below BYPASS (all-ones minus one).
  function automatic int unsigned idcode_opcode(input int unsigned irW);
    return (32'd1 << irW) - 32'd2;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: the serial JTAG pin bundle between a tester and the TAP.
// The master modport is the tester side, the slave modport is the TAP side.
interface jtag_tap_ctrl_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_ctrl_fsm.sv
// jtag_tap_fsm: the 16-state TAP state machine plus capture/shift/update
// enable decode. Enables are pure decodes of the current state, so each one
// is high for exactly the cycles the FSM spends in the matching state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       ck,
  input  logic       rst_n,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q;
  tap_state_e state_d;

  // State register; TRST-style async reset lands in Test-Logic-Reset.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Standard TAP transition graph driven by tms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms_i ? TLR    : RTI;
      RTI:     state_d = tms_i ? SEL_DR : RTI;
      SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms_i ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tms_i ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
      SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms_i ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tms_i ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Enable decode from the current state.
  always_comb begin
    capture_dr_o = 1'b0;
    shift_dr_o   = 1'b0;
    update_dr_o  = 1'b0;
    capture_ir_o = 1'b0;
    shift_ir_o   = 1'b0;
    update_ir_o  = 1'b0;
    case (state_q)
      CAP_DR:  capture_dr_o = 1'b1;
      SH_DR:   shift_dr_o   = 1'b1;
      UPD_DR:  update_dr_o  = 1'b1;
      CAP_IR:  capture_ir_o = 1'b1;
      SH_IR:   shift_ir_o   = 1'b1;
      UPD_IR:  update_ir_o  = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: parametrised JTAG TAP. Wraps the TAP FSM and adds the
// instruction register, opcode decoder, bypass (and optional IDCODE)
// register and the registered TDO mux. External scan chains shift on their
// own; this block only selects them through dr_sel and gates with shift_dr.
// Optional feature macro: JTAG_IDCODE_EN (adds the 32-bit IDCODE register
// and makes IDCODE the reset instruction).
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_W   = 2,
  parameter int          NUM_DR = 2,
  parameter logic [31:0] IDCODE = DEFAULT_IDCODE
) (
  input  logic              ck,
  input  logic              rst_n,
  jtag_tap_ctrl_if.slave    jtag,
  input  logic [NUM_DR-1:0] dr_tdo,
  output logic [3:0]        tap_state,
  output logic              capture_dr,
  output logic              shift_dr,
  output logic              update_dr,
  output logic              capture_ir,
  output logic              shift_ir,
  output logic              update_ir,
  output logic [NUM_DR-1:0] dr_sel,
  output logic [IR_W-1:0]   inst,
  output logic              hold
);

  // Reject parameter combinations that leave no room for BYPASS/IDCODE.
  if (IR_W < 2) begin : gIrWCheck
    $error("jtag_tap_ctrl: IR_W must be at least 2");
  end
  if (NUM_DR > (1 << IR_W) - 2) begin : gNumDrCheck
    $error("jtag_tap_ctrl: NUM_DR must not exceed 2**IR_W-2");
  end
  if (IDCODE[0] != 1'b1) begin : gIdcodeCheck
    $error("jtag_tap_ctrl: IDCODE bit 0 must be 1");
  end

  localparam logic [IR_W-1:0] BYPASS_OP = IR_W'(bypass_opcode(IR_W));
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] IDCODE_OP = IR_W'(idcode_opcode(IR_W));
  localparam logic [IR_W-1:0] RESET_OP  = IDCODE_OP;
`else
  localparam logic [IR_W-1:0] RESET_OP  = BYPASS_OP;
`endif

  tap_state_e        state;
  logic [IR_W-1:0]   ir_shift_q;
  logic [IR_W-1:0]   inst_q;
  logic              bypass_q;
  logic              tdo_q;
  logic              tdo_en_q;
  logic              drLsb;
  logic [NUM_DR-1:0] drSel;

  jtag_tap_fsm u_fsm (
    .ck           (ck),
    .rst_n        (rst_n),
    .tms_i        (jtag.tms),
    .state_o      (state),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir)
  );

  // IR shift stage: capture the fixed 0..01 pattern, shift right with tdi at MSB.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift_q <= '0;
    end else if (capture_ir) begin
      ir_shift_q <= IR_W'(1);
    end else if (shift_ir) begin
      ir_shift_q <= {jtag.tdi, ir_shift_q[IR_W-1:1]};
    end
  end

  // Active instruction only moves in Update-IR, and falls back in Test-Logic-Reset.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      inst_q <= RESET_OP;
    end else if (state == TLR) begin
      inst_q <= RESET_OP;
    end else if (update_ir) begin
      inst_q <= ir_shift_q;
    end
  end

  // One-bit bypass register: cleared on capture, follows tdi while shifting.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      bypass_q <= 1'b0;
    end else if (capture_dr) begin
      bypass_q <= 1'b0;
    end else if (shift_dr) begin
      bypass_q <= jtag.tdi;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_q;

  // IDCODE register: capture reloads the constant, shift sends it out LSB first.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      idcode_q <= IDCODE;
    end else if (capture_dr) begin
      idcode_q <= IDCODE;
    end else if (shift_dr) begin
      idcode_q <= {jtag.tdi, idcode_q[31:1]};
    end
  end
`endif

  // Opcode decode: low opcodes pick an external chain, the rest fall to bypass/IDCODE.
  always_comb begin
    drSel = '0;
    drLsb = bypass_q;
`ifdef JTAG_IDCODE_EN
    if (inst_q == IDCODE_OP) begin
      drLsb = idcode_q[0];
    end
`endif
    for (int k = 0; k < NUM_DR; k++) begin
      if (inst_q == IR_W'(k)) begin
        drSel[k] = 1'b1;
        drLsb    = dr_tdo[k];
      end
    end
  end

  // Registered TDO: launch the selected LSB from either shift state, else hold.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else if (shift_ir) begin
      tdo_q    <= ir_shift_q[0];
      tdo_en_q <= 1'b1;
    end else if (shift_dr) begin
      tdo_q    <= drLsb;
      tdo_en_q <= 1'b1;
    end else begin
      tdo_en_q <= 1'b0;
    end
  end

  assign jtag.tdo    = tdo_q;
  assign jtag.tdo_en = tdo_en_q;
  assign tap_state   = state;
  assign inst        = inst_q;
  assign dr_sel      = drSel;
  assign hold        = |drSel;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: scoreboard bench for jtag_tap_ctrl. The stimulus side
// drives tms/tdi/dr_tdo, advances a queue-based reference TAP model and
// pushes the expected post-edge outputs; a separate monitor pops one entry
// per clock and compares it against the DUT.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  localparam int          IR_W   = 2;
  localparam int          NUM_DR = 2;
  localparam logic [31:0] IDC    = 32'h0000_0765;
`ifdef JTAG_IDCODE_EN
  localparam int RST_OP = (1 << IR_W) - 2;
`else
  localparam int RST_OP = (1 << IR_W) - 1;
`endif

  typedef struct {
    logic [3:0]        st;
    logic [IR_W-1:0]   inst;
    logic [NUM_DR-1:0] sel;
    logic              hold;
    logic [5:0]        en;
    logic              tdo;
    logic              tdoEn;
  } exp_t;

  logic              ck = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_DR-1:0] dr_tdo = '0;
  logic [3:0]        tap_state;
  logic              capture_dr, shift_dr, update_dr;
  logic              capture_ir, shift_ir, update_ir;
  logic [NUM_DR-1:0] dr_sel;
  logic [IR_W-1:0]   inst;
  logic              hold;

  jtag_tap_ctrl_if jif ();

  jtag_tap_ctrl #(.IR_W(IR_W), .NUM_DR(NUM_DR), .IDCODE(IDC)) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .jtag       (jif),
    .dr_tdo     (dr_tdo),
    .tap_state  (tap_state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .dr_sel     (dr_sel),
    .inst       (inst),
    .hold       (hold)
  );

  always #5 ck = ~ck;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  // Reference model: state graph as lookup tables, shift registers as bit queues (LSB at front).
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] mState;
  int         mInst;
  bit         irQ[$];
  bit         byQ[$];
`ifdef JTAG_IDCODE_EN
  bit         idQ[$];
`endif
  bit         mTdo;
  bit         mTdoEn;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fillTables();
    nxt0[TLR]    = RTI;    nxt1[TLR]    = TLR;
    nxt0[RTI]    = RTI;    nxt1[RTI]    = SEL_DR;
    nxt0[SEL_DR] = CAP_DR; nxt1[SEL_DR] = SEL_IR;
    nxt0[CAP_DR] = SH_DR;  nxt1[CAP_DR] = EX1_DR;
    nxt0[SH_DR]  = SH_DR;  nxt1[SH_DR]  = EX1_DR;
    nxt0[EX1_DR] = PAU_DR; nxt1[EX1_DR] = UPD_DR;
    nxt0[PAU_DR] = PAU_DR; nxt1[PAU_DR] = EX2_DR;
    nxt0[EX2_DR] = SH_DR;  nxt1[EX2_DR] = UPD_DR;
    nxt0[UPD_DR] = RTI;    nxt1[UPD_DR] = SEL_DR;
    nxt0[SEL_IR] = CAP_IR; nxt1[SEL_IR] = TLR;
    nxt0[CAP_IR] = SH_IR;  nxt1[CAP_IR] = EX1_IR;
    nxt0[SH_IR]  = SH_IR;  nxt1[SH_IR]  = EX1_IR;
    nxt0[EX1_IR] = PAU_IR; nxt1[EX1_IR] = UPD_IR;
    nxt0[PAU_IR] = PAU_IR; nxt1[PAU_IR] = EX2_IR;
    nxt0[EX2_IR] = SH_IR;  nxt1[EX2_IR] = UPD_IR;
    nxt0[UPD_IR] = RTI;    nxt1[UPD_IR] = SEL_DR;
  endfunction

  function automatic void modelReset();
    mState = TLR;
    mInst  = RST_OP;
    irQ.delete();
    for (int i = 0; i < IR_W; i++) irQ.push_back(1'b0);
    byQ.delete();
    byQ.push_back(1'b0);
`ifdef JTAG_IDCODE_EN
    idQ.delete();
    for (int i = 0; i < 32; i++) idQ.push_back(1'b0);
`endif
    mTdo   = 1'b0;
    mTdoEn = 1'b0;
  endfunction

  // Advance the model by one rising edge with the given pin values.
  function automatic void modelStep(input bit t, input bit d);
    logic [31:0] idv;
    mTdoEn = 1'b0;
    if (mState == SH_IR) begin
      mTdo = irQ.pop_front();
      irQ.push_back(d);
      mTdoEn = 1'b1;
    end else if (mState == SH_DR) begin
      if (mInst < NUM_DR) begin
        mTdo = dr_tdo[mInst];
`ifdef JTAG_IDCODE_EN
      end else if (mInst == (1 << IR_W) - 2) begin
        mTdo = idQ.pop_front();
        idQ.push_back(d);
`endif
      end else begin
        mTdo = byQ.pop_front();
        byQ.push_back(d);
      end
      mTdoEn = 1'b1;
    end
    if (mState == CAP_IR) begin
      irQ.delete();
      for (int i = 0; i < IR_W; i++) irQ.push_back(i == 0);
    end
    if (mState == CAP_DR) begin
      byQ.delete();
      byQ.push_back(1'b0);
      idv = IDC;
`ifdef JTAG_IDCODE_EN
      idQ.delete();
      for (int i = 0; i < 32; i++) idQ.push_back(idv[i]);
`endif
    end
    if (mState == UPD_IR) begin
      mInst = 0;
      for (int i = 0; i < IR_W; i++) mInst += int'(irQ[i]) << i;
    end
    if (mState == TLR) mInst = RST_OP;
    mState = t ? nxt1[mState] : nxt0[mState];
  endfunction

  function automatic exp_t makeExp();
    exp_t e;
    e.st    = mState;
    e.inst  = IR_W'(mInst);
    e.sel   = (mInst < NUM_DR) ? NUM_DR'(1 << mInst) : '0;
    e.hold  = (mInst < NUM_DR);
    e.en    = {mState == CAP_DR, mState == SH_DR, mState == UPD_DR,
               mState == CAP_IR, mState == SH_IR, mState == UPD_IR};
    e.tdo   = mTdo;
    e.tdoEn = mTdoEn;
    return e;
  endfunction

  function automatic void checkOutput(input exp_t e);
    chk("tapState", 32'(tap_state), 32'(e.st));
    chk("inst",     32'(inst),      32'(e.inst));
    chk("drSel",    32'(dr_sel),    32'(e.sel));
    chk("hold",     32'(hold),      32'(e.hold));
    chk("enables",  32'({capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir}), 32'(e.en));
    chk("tdoEn",    32'(jif.tdo_en), 32'(e.tdoEn));
    chk("tdo",      32'(jif.tdo),    32'(e.tdo));
  endfunction

  // One clock of stimulus: drive at the falling edge, predict, enqueue.
  task automatic applyStimulus(input bit t, input bit d);
    @(negedge ck);
    jif.tms = t;
    jif.tdi = d;
    dr_tdo  = NUM_DR'($urandom);
    modelStep(t, d);
    expQ.push_back(makeExp());
  endtask

  task automatic goRti();
    repeat (5) applyStimulus(1'b1, 1'($urandom));
    applyStimulus(1'b0, 1'($urandom));
  endtask

  task automatic irScan(input logic [IR_W-1:0] v);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) applyStimulus(i == IR_W - 1, v[i]);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic drScan(input int n, input logic [63:0] bits);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(i == n - 1, bits[i]);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // Async reset pulse between edges; the reset state must appear without a clock.
  task automatic resetPulse();
    @(negedge ck);
    rst_n   = 1'b0;
    jif.tms = 1'b1;
    modelReset();
    #1;
    chk("asyncState", 32'(tap_state), 32'hF);
    chk("asyncTdoEn", 32'(jif.tdo_en), 32'h0);
    chk("asyncInst",  32'(inst), 32'(RST_OP));
    expQ.push_back(makeExp());
    @(negedge ck);
    expQ.push_back(makeExp());
    @(negedge ck);
    rst_n = 1'b1;
    modelStep(1'b1, jif.tdi);
    expQ.push_back(makeExp());
  endtask

  // Monitor: one expected entry per clock, sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge ck);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized mix.
  initial begin
    fillTables();
    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    rst_n   = 1'b0;
    modelReset();
    repeat (2) @(negedge ck);
    $display("[TB] reset state check");
    checkOutput(makeExp());
    rst_n = 1'b1;

    goRti();
    irScan(2'b10);
    irScan(2'b11);
    drScan(4, 64'b1101);
    irScan(2'b01);
    drScan(12, {$urandom, $urandom});
    irScan(2'b00);
    drScan(6, {$urandom, $urandom});

`ifdef JTAG_IDCODE_EN
    resetPulse();
    goRti();
    drScan(32, {$urandom, $urandom});
`endif

    goRti();
    repeat (5) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);

    goRti();
    irScan(2'b11);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'($urandom));
    resetPulse();

    for (int op = 0; op < 60; op++) begin
      case ($urandom_range(0, 3))
        0: begin goRti(); irScan(IR_W'($urandom)); end
        1: begin goRti(); drScan($urandom_range(1, 40), {$urandom, $urandom}); end
        2: begin
          repeat ($urandom_range(1, 20)) applyStimulus(1'($urandom), 1'($urandom));
        end
        default: begin
          goRti();
          applyStimulus(1'b1, 1'b0);
          applyStimulus(1'b0, 1'b0);
          applyStimulus(1'b0, 1'b0);
          repeat ($urandom_range(0, 5)) applyStimulus(1'b0, 1'($urandom));
          resetPulse();
        end
      endcase
    end

    repeat (3) @(negedge ck);
    chk("queueDrained", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
